mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS datapath. Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers.
- Provides a busy/stall handshake so the single-cycle core freezes its PC while an operation is in flight.
- Also services MTHI/MTLO writes. Results are read combinationally for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately.
- start  input  1  launch the operation selected by op; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high whenever state != IDLE; drives CPU stall.
- done  output  1  one-cycle pulse when hi/lo take a new result.

Behaviour:
- Reset (rst=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, all internal registers cleared. Reset during RUN/FIX aborts the operation with no HI/LO update.
- States and transitions:
  - IDLE: start=1 latches op, magnitudes of a/b (signed ops take two's-complement absolute value), the sign flags and a divide-by-zero flag, clears the iteration counter, then goes to RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After WIDTH steps, goes to FIX.
  - FIX: applies sign correction and writes hi/lo at the end of the cycle, then goes to IDLE.
- Latency: start sampled at edge 0. busy is high from edge 0 through edge WIDTH+1, i.e. WIDTH+1 cycles. New hi/lo values and done=1 are visible in the cycle after edge WIDTH+1 (WIDTH+2 edges total, 34 for WIDTH=32). busy is 0 in that same cycle. Latency is fixed for all ops and operands.
- Multiply: 2*WIDTH-bit product; hi = upper half, lo = lower half. MULT negates the product when the operand signs differ.
- Divide: lo = quotient, hi = remainder.
  - DIV: quotient negated when the signs differ; remainder takes the dividend's sign.
  - DIV of the most-negative value by -1 gives lo=0x80000000, hi=0.
- Divide by zero (b=0, DIVU or DIV): full latency is still used; forced result lo = all ones, hi = original a.
- start while busy is ignored; the running op continues unaffected.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; each writes wdata to its register at the next edge.
  - Both may be asserted together.
  - Ignored while busy or when start=1 in the same cycle (start wins).
  - done is not pulsed for MTHI/MTLO.
- done is high for exactly one cycle per completed op and is never asserted by reset.
- hi/lo hold their values during RUN/FIX. Old values remain readable until the FIX edge.
- No combinational path from start to busy; busy is registered state only.

Test Plan:
- Reset (rst=0, async) applied mid-cycle -> hi=lo=0, busy=0, done=0 immediately. Release rst, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 in one cycle -> hi=0x12345678, lo=0x9ABCDEF0 after next edge; done stays 0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles. hi=0xFFFFFFFE, lo=0x00000001 and done=1 in the cycle after edge 33, with busy=0.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> after 34 edges lo=0xFFFFFFFF, hi=100. DIVU a=100, b=7 -> lo=14, hi=2.
- During a MULTU, pulse start with op=DIVU and assert hi_we with wdata=0xDEADBEEF -> both ignored. Original product lands on schedule; a single done pulse.
- Start MULT, drive rst=0 at RUN iteration 10 -> busy drops immediately, hi/lo=0, no done. After release, a new MULTU 6*7 completes with lo=42, hi=0.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer owning the MIPS HI/LO registers.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start, op    launch MULTU(00) / MULT(01) / DIVU(10) / DIV(11), sampled in IDLE only
//   a, b         rs / rt operands
//   hi_we, lo_we MTHI / MTLO strobes writing wdata, honoured in IDLE with start low
//   hi, lo       architectural HI / LO registers
//   busy         high while an operation is in flight (registered)
//   done         one-cycle pulse when hi/lo receive a result
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0] step, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, res_hi, res_lo;

    always_comb begin
        a_mag    = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag    = (op[0] && b[WIDTH-1]) ? -b : b;
        // Multiply: P = {partial, multiplier}; add multiplicand into the upper half, shift right.
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        // Divide: P = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
        div_rem  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, m_q};
        step     = !div_q ? {mul_sum, p_q[WIDTH-1:1]}
                 : div_diff[WIDTH] ? {div_rem[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                 : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        prod_fix = neg_q ? -p_q : p_q;
        q_fix    = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        r_fix    = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        res_hi   = !div_q ? prod_fix[2*WIDTH-1:WIDTH] : dz_q ? a_q : r_fix;
        res_lo   = !div_q ? prod_fix[WIDTH-1:0] : dz_q ? '1 : q_fix;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        p_d     = p_q;
        m_d     = m_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    div_d   = op[1];
                    neg_d   = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d  = op[0] & a[WIDTH-1];
                    dz_d    = op[1] & (b == '0);
                    p_d     = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    m_d     = op[1] ? b_mag : a_mag;
                    a_d     = a;
                end else begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                end
            end
            RUN: begin
                p_d     = step;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            p_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            p_q     <= p_d;
            m_q     <= m_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq against an arithmetic reference model.
module tb_mdu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    // Architectural result {hi, lo} straight from the instruction definitions.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00: return {32'b0, x} * {32'b0, y};
            2'b01: return sx * sy;
            2'b10: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string nm, input bit inject);
        logic [63:0] e;
        int k, bc;
        bit hold_ok;
        e = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        k = 0; bc = 0; hold_ok = 1'b1;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) bc++;
            if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
            if (inject && k == 5) begin
                start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd3;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
            end else if (inject && k == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            tick();
            k++;
        end
        checks++;
        if (k !== W + 1) begin failures++; $display("FAIL %s latency: got %0d cycles, want %0d", nm, k, W + 1); end
        checks++;
        if (bc !== W + 1) begin failures++; $display("FAIL %s busy_cycles: got %0d, want %0d", nm, bc, W + 1); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done: got %b, want 0", nm, busy); end
        checks++;
        if (!hold_ok) begin failures++; $display("FAIL %s hilo_hold: got changed, want %h/%h", nm, exp_hi, exp_lo); end
        checks++;
        if (hi !== e[63:32]) begin failures++; $display("FAIL %s hi: got %h, want %h", nm, hi, e[63:32]); end
        checks++;
        if (lo !== e[31:0]) begin failures++; $display("FAIL %s lo: got %h, want %h", nm, lo, e[31:0]); end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s after_done: got done=%b busy=%b, want 0 0", nm, done, busy);
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            failures++; $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b, want zeros", hi, lo, busy, done);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mt();
        hi_we = 1'b1; wdata = 32'h12345678;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABCDEF0;
        checks++;
        if (hi !== 32'h12345678 || done !== 0) begin
            failures++; $display("FAIL mthi: got hi=%h done=%b, want 12345678 0", hi, done);
        end
        tick();
        lo_we = 1'b0;
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || done !== 0) begin
            failures++; $display("FAIL mtlo: got hi=%h lo=%h done=%b, want 12345678 9abcdef0 0", hi, lo, done);
        end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        checks++;
        if (hi !== 32'h0BADF00D || lo !== 32'h0BADF00D || done !== 0 || busy !== 0) begin
            failures++; $display("FAIL mt_both: got hi=%h lo=%h done=%b busy=%b, want 0badf00d x2 0 0", hi, lo, done, busy);
        end
        exp_hi = 32'h0BADF00D;
        exp_lo = 32'h0BADF00D;
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #4 rst = 1'b0;
        #1;
        checks++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            failures++; $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b, want zeros", hi, lo, busy, done);
        end
        #2 rst = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        tick();
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 1'b0);
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            failures++; $display("FAIL multu_max_const: got %h/%h, want fffffffe/00000001", hi, lo);
        end
        run_op(2'b01, 32'hFFFFFFFD, 32'd7, "mult_neg", 1'b0);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, "div_neg", 1'b0);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            failures++; $display("FAIL div_neg_const: got %h/%h, want ffffffff/fffffffd", hi, lo);
        end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, "div_min_m1", 1'b0);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            failures++; $display("FAIL div_min_m1_const: got %h/%h, want 00000000/80000000", hi, lo);
        end
        run_op(2'b10, 32'd100, 32'd0, "divu_zero", 1'b0);
        run_op(2'b11, 32'hFFFFFF00, 32'd0, "div_zero", 1'b0);
        run_op(2'b10, 32'd100, 32'd7, "divu_100_7", 1'b0);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            failures++; $display("FAIL divu_100_7_const: got %h/%h, want 2/14", hi, lo);
        end
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, "div_pos_neg", 1'b0);
        run_op(2'b01, 32'h80000000, 32'h80000000, "mult_min_min", 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_op(2'b00, 32'h00012345, 32'h00006789, "busy_ignore", 1'b1);
    endtask

    task automatic test_start_beats_mt();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEBABE;
        run_op(2'b01, 32'hFFFFFFF0, 32'h00000010, "start_beats_mt", 1'b0);
    endtask

    task automatic test_abort();
        bit quiet;
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFFB; b = 32'd9;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #3 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 0 || hi !== 0 || lo !== 0 || done !== 0) begin
            failures++; $display("FAIL abort_reset: got busy=%b hi=%h lo=%h done=%b, want zeros", busy, hi, lo, done);
        end
        #1 rst = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        quiet = 1'b1;
        repeat (40) begin
            tick();
            if (done !== 0 || busy !== 0 || hi !== 0 || lo !== 0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL abort_quiet: got activity after abort, want idle zeros"); end
        run_op(2'b00, 32'd6, 32'd7, "multu_6_7", 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic [1:0] o;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (i % 6 == 0) y = 32'd0;
            if (i % 5 == 1) y = 32'($urandom_range(1, 15));
            if (i % 7 == 2) x = 32'h80000000;
            run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mid_reset();
        test_directed();
        test_busy_ignore();
        test_start_beats_mt();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
